// File: rtl/buzz_pkg.sv
// Shared types and constants for the buzzer sequencer: FSM states, beep pattern
// records and the per-requester pattern table.
package buzz_pkg;

    localparam int HP_W    = 17;
    localparam int TIMER_W = 10;
    localparam int BEEP_W  = 3;

    // Tone generator toggle limits at 100 MHz (A4, A5, A6)
    localparam logic [HP_W-1:0] HP_A4 = 17'd113636;
    localparam logic [HP_W-1:0] HP_A5 = 17'd56818;
    localparam logic [HP_W-1:0] HP_A6 = 17'd28409;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [BEEP_W-1:0]  beeps;
        logic [TIMER_W-1:0] on_ms;
        logic [TIMER_W-1:0] off_ms;
        logic [HP_W-1:0]    half_period;
    } pattern_t;

    localparam pattern_t PAT0 = '{beeps: 3'd1, on_ms: 10'd50,  off_ms: 10'd0,   half_period: HP_A4};
    localparam pattern_t PAT1 = '{beeps: 3'd2, on_ms: 10'd100, off_ms: 10'd100, half_period: HP_A5};
    localparam pattern_t PAT2 = '{beeps: 3'd3, on_ms: 10'd200, off_ms: 10'd200, half_period: HP_A4};
    localparam pattern_t PAT3 = '{beeps: 3'd5, on_ms: 10'd500, off_ms: 10'd250, half_period: HP_A6};

    localparam pattern_t [3:0] PATTERNS = {PAT3, PAT2, PAT1, PAT0};

    function automatic logic [3:0] id_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

    function automatic logic [1:0] highest_id(input logic [3:0] bits);
        logic [1:0] id;
        id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bits[i]) id = 2'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/buzz_tick_gen.sv
// Timing-tick prescaler: counts 0..DIV-1 and pulses tick on the last count;
// restart forces the count back to 0 so every phase starts on a fresh tick period.
module buzz_tick_gen #(
    parameter int unsigned DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] count;

    assign tick = (count == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/buzzer_sequencer.sv
// Arbitrates four alarm requesters onto the PmodAMP2 tone generator, playing each
// requester's fixed beep pattern. Define BUZZ_CANCEL_EN to add the cancel[3:0] input.
module buzzer_sequencer
    import buzz_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned GAP_MS  = 100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic            no_buzz,
`ifdef BUZZ_CANCEL_EN
    input  logic [3:0]      cancel,
`endif
    output logic            buzzer_on,
    output logic [HP_W-1:0] tone_half_period,
    output logic            busy,
    output logic [1:0]      active_id,
    output logic [3:0]      done
);

    localparam int unsigned        DIV   = CLK_HZ / TICK_HZ;
    localparam logic [TIMER_W-1:0] GAP_T = TIMER_W'(GAP_MS);

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] limit;
    logic [BEEP_W-1:0]  beep_cnt;
    logic [3:0]         pending, pending_next;
    logic [3:0]         accept, clear, higher_mask, cancel_mask;
    logic [1:0]         grant_id;
    logic               tick, restart, phase_end, cancel_active;
    logic               grant, beep_dec, finish, abort;

`ifdef BUZZ_CANCEL_EN
    assign cancel_mask   = cancel;
    assign cancel_active = ((state == ST_ON) || (state == ST_OFF)) && cancel[active_id];
`else
    assign cancel_mask   = 4'd0;
    assign cancel_active = 1'b0;
`endif

    assign grant_id    = highest_id(pending);
    assign higher_mask = 4'b1110 << active_id;
    assign restart     = (state_next != state);
    assign phase_end   = tick && (timer == limit - TIMER_W'(1));

    buzz_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        limit = GAP_T;
        case (state)
            ST_ON:   limit = PATTERNS[active_id].on_ms;
            ST_OFF:  limit = PATTERNS[active_id].off_ms;
            default: limit = GAP_T;
        endcase
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        beep_dec   = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        if (no_buzz) begin
            state_next = ST_IDLE;
        end else if (cancel_active) begin
            state_next = ST_GAP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        state_next = ST_ON;
                        grant      = 1'b1;
                    end
                end
                ST_ON: begin
                    if (phase_end) begin
                        beep_dec = 1'b1;
                        if (beep_cnt == BEEP_W'(1)) begin
                            state_next = ST_GAP;
                            finish     = 1'b1;
                        end else begin
                            state_next = ST_OFF;
                        end
                    end
                end
                ST_OFF: begin
                    // Preemption is only considered here so a beep is never clipped
                    if (phase_end) begin
                        if (|(pending & higher_mask)) begin
                            state_next = ST_IDLE;
                            abort      = 1'b1;
                        end else begin
                            state_next = ST_ON;
                        end
                    end
                end
                ST_GAP: begin
                    if (phase_end) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        accept = req & ~(busy ? id_onehot(active_id) : 4'd0);
        clear  = (finish || abort) ? id_onehot(active_id) : 4'd0;
        if (no_buzz) begin
            pending_next = 4'd0;
        end else begin
            pending_next = (pending | accept) & ~clear & ~cancel_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            pending          <= 4'd0;
            timer            <= '0;
            beep_cnt         <= '0;
            buzzer_on        <= 1'b0;
            tone_half_period <= '0;
            busy             <= 1'b0;
            active_id        <= 2'd0;
            done             <= 4'd0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            buzzer_on <= (state_next == ST_ON);
            busy      <= (state_next != ST_IDLE);
            done      <= finish ? id_onehot(active_id) : 4'd0;
            if (restart) begin
                timer <= '0;
            end else if (tick) begin
                timer <= timer + TIMER_W'(1);
            end
            if (grant) begin
                active_id        <= grant_id;
                tone_half_period <= PATTERNS[grant_id].half_period;
                beep_cnt         <= PATTERNS[grant_id].beeps;
            end else if (beep_dec) begin
                beep_cnt <= beep_cnt - BEEP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Randomized scoreboard bench for buzzer_sequencer against a time-stamp based reference model.
module tb_buzzer_sequencer;

    localparam int TB_CLK_HZ  = 2;
    localparam int TB_TICK_HZ = 1;
    localparam int TB_GAP_MS  = 100;
    localparam int DIV        = TB_CLK_HZ / TB_TICK_HZ;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        no_buzz;
`ifdef BUZZ_CANCEL_EN
    logic [3:0]  cancel;
`endif
    logic        buzzer_on;
    logic [16:0] tone_half_period;
    logic        busy;
    logic [1:0]  active_id;
    logic [3:0]  done;

    always #5 clk = ~clk;

    buzzer_sequencer #(
        .CLK_HZ (TB_CLK_HZ),
        .TICK_HZ(TB_TICK_HZ),
        .GAP_MS (TB_GAP_MS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .no_buzz         (no_buzz),
`ifdef BUZZ_CANCEL_EN
        .cancel          (cancel),
`endif
        .buzzer_on       (buzzer_on),
        .tone_half_period(tone_half_period),
        .busy            (busy),
        .active_id       (active_id),
        .done            (done)
    );

    // Pattern table as written in the datasheet: beeps, on ms, off ms, half period
    int beeps_t [4] = '{1, 2, 3, 5};
    int on_t    [4] = '{50, 100, 200, 500};
    int off_t   [4] = '{0, 100, 200, 250};
    int hp_t    [4] = '{113636, 56818, 113636, 28409};

    typedef struct { int cyc; int id; int hp; } rise_t;
    typedef struct { int cyc; logic [3:0] bits; } done_t;
    typedef enum int { M_IDLE, M_ON, M_OFF, M_GAP } mphase_e;

    rise_t rise_q [$];
    int    fall_q [$];
    done_t done_q [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mphase_e    mp = M_IDLE;
    bit [3:0]   mpend, acc, clr, cmask;
    int         mid, mhp, mleft, mend;
    bit         was_on, was_busy, cut, started = 1'b0;

    function automatic int top_pending(input bit [3:0] p);
        for (int i = 3; i >= 0; i--) if (p[i]) return i;
        return 0;
    endfunction

    // Reference model: phases end at absolute cycle stamps computed from the table
    always @(posedge clk) begin
        rise_t r;
        done_t d;
        cyc++;
        was_on   = (mp == M_ON);
        was_busy = (mp != M_IDLE);
        clr = '0; cmask = '0; cut = 1'b0;
        if (rst) begin
            mp = M_IDLE; mpend = '0; mid = 0; mhp = 0; started = 1'b1;
        end else if (no_buzz) begin
            mp = M_IDLE; mpend = '0;
        end else begin
            acc = req;
            if (was_busy) acc[mid] = 1'b0;
`ifdef BUZZ_CANCEL_EN
            cmask = cancel;
            if ((mp == M_ON || mp == M_OFF) && cancel[mid]) begin
                mp = M_GAP; mend = cyc + TB_GAP_MS * DIV; cut = 1'b1;
            end
`endif
            if (!cut) begin
                case (mp)
                    M_IDLE: if (mpend != 0) begin
                        mid = top_pending(mpend); mhp = hp_t[mid]; mleft = beeps_t[mid];
                        mp = M_ON; mend = cyc + on_t[mid] * DIV;
                    end
                    M_ON: if (cyc == mend) begin
                        mleft--;
                        if (mleft == 0) begin
                            mp = M_GAP; mend = cyc + TB_GAP_MS * DIV; clr[mid] = 1'b1;
                            d.cyc = cyc; d.bits = 4'b0001 << mid; done_q.push_back(d);
                        end else begin
                            mp = M_OFF; mend = cyc + off_t[mid] * DIV;
                        end
                    end
                    M_OFF: if (cyc == mend) begin
                        if ((mpend >> (mid + 1)) != 0) begin
                            clr[mid] = 1'b1; mp = M_IDLE;
                        end else begin
                            mp = M_ON; mend = cyc + on_t[mid] * DIV;
                        end
                    end
                    M_GAP: if (cyc == mend) mp = M_IDLE;
                    default: mp = M_IDLE;
                endcase
            end
            mpend = (mpend | acc) & ~clr & ~cmask;
        end
        if (mp == M_ON && !was_on) begin
            r.cyc = cyc; r.id = mid; r.hp = mhp; rise_q.push_back(r);
        end
        if (mp != M_ON && was_on) fall_q.push_back(cyc);
    end

    // Monitor: pops expected events whenever the DUT shows one (or one is due)
    logic prev_on = 1'b0;
    always @(negedge clk) begin
        rise_t r;
        done_t d;
        int    f;
        logic [19:0] exp_st;
        if (started) begin
            if ((buzzer_on && !prev_on) || (rise_q.size() > 0 && rise_q[0].cyc <= cyc)) begin
                checks++;
                if (rise_q.size() == 0) begin
                    errors++; $display("FAIL buzzer_rise: unexpected rise at cycle %0d", cyc);
                end else begin
                    r = rise_q.pop_front();
                    if (!(buzzer_on && !prev_on) || r.cyc != cyc || r.id != int'(active_id) || r.hp != int'(tone_half_period)) begin
                        errors++;
                        $display("FAIL buzzer_rise: got rise=%0b cyc=%0d id=%0d hp=%0d, expected cyc=%0d id=%0d hp=%0d",
                                 buzzer_on && !prev_on, cyc, active_id, tone_half_period, r.cyc, r.id, r.hp);
                    end
                end
            end
            if ((!buzzer_on && prev_on) || (fall_q.size() > 0 && fall_q[0] <= cyc)) begin
                checks++;
                if (fall_q.size() == 0) begin
                    errors++; $display("FAIL buzzer_fall: unexpected fall at cycle %0d", cyc);
                end else begin
                    f = fall_q.pop_front();
                    if (!(!buzzer_on && prev_on) || f != cyc) begin
                        errors++; $display("FAIL buzzer_fall: got fall=%0b at cycle %0d, expected cycle %0d", !buzzer_on && prev_on, cyc, f);
                    end
                end
            end
            if (done != 4'd0 || (done_q.size() > 0 && done_q[0].cyc <= cyc)) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++; $display("FAIL done_pulse: unexpected done=%b at cycle %0d", done, cyc);
                end else begin
                    d = done_q.pop_front();
                    if (done !== d.bits || d.cyc != cyc) begin
                        errors++; $display("FAIL done_pulse: got done=%b at cycle %0d, expected %b at cycle %0d", done, cyc, d.bits, d.cyc);
                    end
                end
            end
            exp_st = {(mp != M_IDLE), 2'(mid), 17'(mhp)};
            checks++;
            if ({busy, active_id, tone_half_period} !== exp_st) begin
                errors++;
                $display("FAIL status: cycle %0d got busy=%b id=%0d hp=%0d, expected busy=%b id=%0d hp=%0d",
                         cyc, busy, active_id, tone_half_period, exp_st[19], exp_st[18:17], exp_st[16:0]);
            end
            prev_on = buzzer_on;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] r);
        @(negedge clk); req = r;
        @(negedge clk); req = 4'd0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((mp != M_IDLE || mpend != 0 || busy !== 1'b0) && n < budget) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= budget) begin
            errors++; $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++; $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'd0; no_buzz = 1'b0;
`ifdef BUZZ_CANCEL_EN
        cancel = 4'd0;
`endif
        wait_cycles(3);
        rst = 1'b0;
        check_val("reset_buzzer_on", int'(buzzer_on), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_active_id", int'(active_id), 0);
        check_val("reset_tone", int'(tone_half_period), 0);
        check_val("reset_done", int'(done), 0);

        // Single requester, two beeps
        pulse(4'b0010);
        wait_idle(2000);
        // Simultaneous low and high priority
        pulse(4'b1001);
        wait_idle(10000);
        // Higher priority arrives during the first OFF of id 2
        pulse(4'b0100);
        wait_cycles(500);
        pulse(4'b1000);
        wait_idle(10000);
        // Mute mid-beep, request while muted
        pulse(4'b1000);
        wait_cycles(300);
        @(negedge clk); no_buzz = 1'b1;
        wait_cycles(2);
        pulse(4'b1000);
        @(negedge clk); no_buzz = 1'b0;
        wait_cycles(20);
        check_val("mute_busy", int'(busy), 0);
        check_val("mute_buzzer_on", int'(buzzer_on), 0);
        wait_idle(100);
        // Repeated request for the active id
        pulse(4'b0100);
        wait_cycles(100);
        pulse(4'b0100);
        wait_cycles(500);
        pulse(4'b0100);
        wait_idle(3000);
`ifdef BUZZ_CANCEL_EN
        pulse(4'b1000);
        wait_cycles(300);
        @(negedge clk); cancel = 4'b1000;
        @(negedge clk); cancel = 4'd0;
        wait_idle(1000);
`endif
        // Random traffic with sparse mutes and one mid-run reset
        for (int n = 0; n < 30000; n++) begin
            @(negedge clk);
            req     = ($urandom_range(0, 299) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            no_buzz = ($urandom_range(0, 3999) == 0);
            rst     = (n == 15000 || n == 15001);
`ifdef BUZZ_CANCEL_EN
            cancel  = ($urandom_range(0, 1999) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
`endif
        end
        @(negedge clk);
        req = 4'd0; no_buzz = 1'b0; rst = 1'b0;
`ifdef BUZZ_CANCEL_EN
        cancel = 4'd0;
`endif
        wait_idle(20000);
        wait_cycles(4);
        check_val("pending_rises", rise_q.size(), 0);
        check_val("pending_falls", fall_q.size(), 0);
        check_val("pending_dones", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_sequencer.md
# buzzer_sequencer

Sequences and arbitrates the PmodAMP2 buzzer tone generator between four alarm requesters. Each requester has a fixed beep pattern: count, on-time, off-time and tone. The block latches request pulses and grants the buzzer to the highest-priority pending requester. It drives the tone generator's enable and half-period inputs and reports completion per requester. It sits between the game/alarm control logic and the tone generator on the Basys3 100 MHz clock domain.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 1000, timing tick rate; all pattern times are in ticks (ms)
- GAP_MS, 100, mandatory silence after every completed pattern

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- req  in  4  per-requester one-cycle request pulses; higher index = higher priority
- no_buzz  in  1  mute; level-sensitive
- buzzer_on  out  1  tone generator enable
- tone_half_period  out  17  tone generator toggle limit in clk cycles
- busy  out  1  high in any state other than IDLE
- active_id  out  2  requester currently holding the buzzer
- done  out  4  one-cycle pulse on pattern completion, per requester

## Operation
- Pattern table, indexed by id as (beeps, on_ms, off_ms, half_period):
  - 0: 1, 50, 0, 113636 (440 Hz)
  - 1: 2, 100, 100, 56818
  - 2: 3, 200, 200, 113636
  - 3: 5, 500, 250, 28409
- pending[3:0]: a req bit sets the matching pending bit on the next edge. A req for the id currently active (busy=1) is discarded.
- FSM states are IDLE, ON, OFF and GAP.
  - IDLE: if any pending bit is set, latch id = highest pending index, load its pattern, set beep counter = beeps, go to ON.
  - ON: buzzer_on=1. After on_ms ticks, decrement the beep counter. If the counter reaches 0, go to GAP; otherwise go to OFF.
  - OFF: buzzer_on=0. After off_ms ticks, if a pending id higher than active_id exists, abort: clear the active pending bit, do not pulse done, go to IDLE. Otherwise go to ON.
  - GAP: on entry, clear pending[active_id] and pulse done[active_id]. After GAP_MS ticks, go to IDLE.
- Preemption happens only at the end of an OFF phase; beeps are never clipped.
- no_buzz high: the next edge forces IDLE, clears all pending bits, and drives buzzer_on=0. Requests are ignored while no_buzz is high, and done is not pulsed for the aborted pattern.
- The tick prescaler counts 0..CLK_HZ/TICK_HZ-1 and restarts at 0 on every state entry, so phases last exactly ms*CLK_HZ/TICK_HZ cycles.
- The state timer is 10 bits wide and the beep counter is 3 bits wide.
- Reset values: state IDLE, pending 0, buzzer_on 0, tone_half_period 0, busy 0, active_id 0, done 0, prescaler 0.

## Timing
- All outputs are registered.
- Request to buzzer_on: req sampled at edge k; pending set at edge k; IDLE transitions to ON at edge k+1; buzzer_on=1 after edge k+1. That is 2 cycles from the req edge.
- tone_half_period and active_id are valid from the IDLE→ON edge and are held until the next grant.
- done pulses on the same edge as the ON→GAP transition.
- A req for an idle id coincident with a GAP-entry clear of a different id is recorded.
- A req coincident with the GAP-entry clear of the same id is discarded.
- Reset asserted mid-pattern: all reset values apply on that edge.

## Configuration
- BUZZ_CANCEL_EN defined: adds input cancel[3:0]. A cancel bit clears its pending bit on the next edge. If it matches active_id, the FSM goes to GAP without a done pulse.
- BUZZ_CANCEL_EN undefined: the cancel port is absent. Pending bits clear only on completion, preemption, no_buzz or rst.

## Structure
- Shared package buzz_pkg holds:
  - the state enum
  - the pattern record typedef and the 4-entry pattern table constant
  - the half-period constants
- One sub-module: buzz_tick_gen, the prescaler with synchronous restart input and tick output.

## Test plan
- req[1] pulse → buzzer_on rises 2 cycles later. Two 100 ms beeps with a 100 ms gap, tone_half_period=56818, done[1] at the end of the second beep, busy low 100 ms later.
- req[0] and req[3] in the same cycle → id 3 pattern runs first, then GAP, then the id 0 50 ms beep; done[3] pulses, then done[0].
- req[3] during the first OFF phase of id 2 → preemption at end of OFF, id 3 starts; done[2] never pulses.
- no_buzz raised mid-ON of id 3 → buzzer_on 0 next cycle, busy 0, pending 0. A req while muted produces no beep.
- req[2] repeated while id 2 is active → discarded; exactly three beeps and one done pulse.
- With BUZZ_CANCEL_EN: cancel[3] mid-pattern → GAP, no done[3]; buzzer silent from the next cycle.
